// File: rtl/l1d_linefill_ctrl_if.sv
// Handshake bundle between the linefill controller and its surroundings:
// MSHR requesters, memory read port, data RAM write port and done pulses.
interface l1d_linefill_ctrl_if #(
  parameter int ENTRY_NUM = 8,
  parameter int ID_W      = 3,
  parameter int TAG_W     = 20,
  parameter int INDEX_W   = 6,
  parameter int WAY_NUM   = 4,
  parameter int OFFSET_W  = 6,
  parameter int BEAT_NUM  = 4,
  parameter int DATA_W    = 128
) ();
  localparam int BEAT_W = $clog2(BEAT_NUM);
  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

  logic [ENTRY_NUM-1:0]         v_req_vld;
  logic [ENTRY_NUM-1:0]         v_req_rdy;
  logic [ENTRY_NUM*TAG_W-1:0]   v_req_tag;
  logic [ENTRY_NUM*INDEX_W-1:0] v_req_index;
  logic [ENTRY_NUM*WAY_NUM-1:0] v_req_way;
  logic                         mem_req_vld;
  logic                         mem_req_rdy;
  logic [ADDR_W-1:0]            mem_req_addr;
  logic [ID_W-1:0]              mem_req_id;
  logic                         mem_rsp_vld;
  logic                         mem_rsp_rdy;
  logic [ID_W-1:0]              mem_rsp_id;
  logic [DATA_W-1:0]            mem_rsp_data;
  logic                         mem_rsp_last;
  logic                         dat_wr_vld;
  logic                         dat_wr_rdy;
  logic [INDEX_W-1:0]           dat_wr_index;
  logic [WAY_NUM-1:0]           dat_wr_way;
  logic [BEAT_W-1:0]            dat_wr_beat;
  logic [DATA_W-1:0]            dat_wr_data;
  logic [ENTRY_NUM-1:0]         v_linefill_done_en;

  modport master (
    input  v_req_vld, v_req_tag, v_req_index, v_req_way,
    input  mem_req_rdy, mem_rsp_vld, mem_rsp_id, mem_rsp_data, mem_rsp_last, dat_wr_rdy,
    output v_req_rdy, mem_req_vld, mem_req_addr, mem_req_id, mem_rsp_rdy,
    output dat_wr_vld, dat_wr_index, dat_wr_way, dat_wr_beat, dat_wr_data, v_linefill_done_en
  );

  modport slave (
    output v_req_vld, v_req_tag, v_req_index, v_req_way,
    output mem_req_rdy, mem_rsp_vld, mem_rsp_id, mem_rsp_data, mem_rsp_last, dat_wr_rdy,
    input  v_req_rdy, mem_req_vld, mem_req_addr, mem_req_id, mem_rsp_rdy,
    input  dat_wr_vld, dat_wr_index, dat_wr_way, dat_wr_beat, dat_wr_data, v_linefill_done_en
  );
endinterface

// File: rtl/l1d_linefill_ctrl.sv
// L1D linefill controller: round-robin issue of MSHR fills, per-id context tracking,
// beat write-back and done pulses. Optional beat checker (err_beat): L1D_LINEFILL_BEAT_CHK_EN.
module l1d_linefill_ctrl #(
  parameter int ENTRY_NUM = 8,
  parameter int ID_W      = 3,
  parameter int TAG_W     = 20,
  parameter int INDEX_W   = 6,
  parameter int WAY_NUM   = 4,
  parameter int OFFSET_W  = 6,
  parameter int BEAT_NUM  = 4,
  parameter int DATA_W    = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  l1d_linefill_ctrl_if.master   bus
`ifdef L1D_LINEFILL_BEAT_CHK_EN
  ,
  output logic                  err_beat
`endif
);
  localparam int BEAT_W = $clog2(BEAT_NUM);
  localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEAT_NUM - 1);

  logic [ENTRY_NUM-1:0] inflight_q, inflight_d;
  logic [ENTRY_NUM-1:0] done_q, done_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 req_vld_q, req_vld_d;
  logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
  logic [ID_W-1:0]      req_id_q, req_id_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [INDEX_W-1:0]   ctx_index_q [ENTRY_NUM];
  logic [INDEX_W-1:0]   ctx_index_d [ENTRY_NUM];
  logic [WAY_NUM-1:0]   ctx_way_q [ENTRY_NUM];
  logic [WAY_NUM-1:0]   ctx_way_d [ENTRY_NUM];
`ifdef L1D_LINEFILL_BEAT_CHK_EN
  logic                 err_q, err_d;
`endif

  logic [ENTRY_NUM-1:0] eligible_s;
  logic [ENTRY_NUM-1:0] grant_s;
  logic [ID_W-1:0]      cand_s;
  logic [ID_W-1:0]      grant_id_s;
  logic                 grant_vld_s;
  logic                 slot_load_s;
  logic                 acc_s;
  logic                 rsp_hs_s;

  // Round-robin pick; an entry whose done pulse is in flight waits one more cycle.
  always_comb begin
    eligible_s  = bus.v_req_vld & ~inflight_q & ~done_q;
    grant_vld_s = 1'b0;
    grant_id_s  = '0;
    cand_s      = '0;
    for (int off = 0; off < ENTRY_NUM; off++) begin
      cand_s = ID_W'((int'(rr_ptr_q) + off) % ENTRY_NUM);
      if (!grant_vld_s && eligible_s[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_id_s  = cand_s;
      end else begin
        grant_id_s  = grant_id_s;
      end
    end
    grant_s = '0;
    if (grant_vld_s) begin
      grant_s[grant_id_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Next-state for the request slot, context table, beat counter and done pulses.
  always_comb begin
    slot_load_s = ~req_vld_q | bus.mem_req_rdy;
    acc_s       = grant_vld_s & slot_load_s;
    rsp_hs_s    = bus.mem_rsp_vld & bus.dat_wr_rdy;

    inflight_d  = inflight_q;
    done_d      = '0;
    rr_ptr_d    = rr_ptr_q;
    req_vld_d   = req_vld_q;
    req_addr_d  = req_addr_q;
    req_id_d    = req_id_q;
    beat_cnt_d  = beat_cnt_q;
    ctx_index_d = ctx_index_q;
    ctx_way_d   = ctx_way_q;

    if (rsp_hs_s && bus.mem_rsp_last) begin
      done_d[bus.mem_rsp_id]     = 1'b1;
      inflight_d[bus.mem_rsp_id] = 1'b0;
      beat_cnt_d                 = '0;
    end else if (rsp_hs_s) begin
      beat_cnt_d = beat_cnt_q + BEAT_W'(1);
    end else begin
      beat_cnt_d = beat_cnt_q;
    end

    if (acc_s) begin
      req_vld_d              = 1'b1;
      req_addr_d             = {bus.v_req_tag[grant_id_s*TAG_W +: TAG_W],
                                bus.v_req_index[grant_id_s*INDEX_W +: INDEX_W],
                                {OFFSET_W{1'b0}}};
      req_id_d               = grant_id_s;
      ctx_index_d[grant_id_s] = bus.v_req_index[grant_id_s*INDEX_W +: INDEX_W];
      ctx_way_d[grant_id_s]   = bus.v_req_way[grant_id_s*WAY_NUM +: WAY_NUM];
      inflight_d[grant_id_s]  = 1'b1;
      rr_ptr_d               = ID_W'((int'(grant_id_s) + 1) % ENTRY_NUM);
    end else if (bus.mem_req_rdy) begin
      req_vld_d = 1'b0;
    end else begin
      req_vld_d = req_vld_q;
    end

`ifdef L1D_LINEFILL_BEAT_CHK_EN
    err_d = err_q;
    if (bus.mem_rsp_vld &&
        (( bus.mem_rsp_last && (beat_cnt_q != LAST_BEAT)) ||
         (!bus.mem_rsp_last && (beat_cnt_q == LAST_BEAT)) ||
         !inflight_q[bus.mem_rsp_id])) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
`endif
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= '0;
      done_q     <= '0;
      rr_ptr_q   <= '0;
      req_vld_q  <= 1'b0;
      req_addr_q <= '0;
      req_id_q   <= '0;
      beat_cnt_q <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        ctx_index_q[i] <= '0;
        ctx_way_q[i]   <= '0;
      end
`ifdef L1D_LINEFILL_BEAT_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      rr_ptr_q    <= rr_ptr_d;
      req_vld_q   <= req_vld_d;
      req_addr_q  <= req_addr_d;
      req_id_q    <= req_id_d;
      beat_cnt_q  <= beat_cnt_d;
      ctx_index_q <= ctx_index_d;
      ctx_way_q   <= ctx_way_d;
`ifdef L1D_LINEFILL_BEAT_CHK_EN
      err_q       <= err_d;
`endif
    end
  end

  // Grants are held off while reset is asserted so no requester sees a phantom accept.
  assign bus.v_req_rdy          = grant_s & {ENTRY_NUM{slot_load_s & rst_n}};
  assign bus.mem_req_vld        = req_vld_q;
  assign bus.mem_req_addr       = req_addr_q;
  assign bus.mem_req_id         = req_id_q;
  assign bus.mem_rsp_rdy        = bus.dat_wr_rdy;
  assign bus.dat_wr_vld         = bus.mem_rsp_vld;
  assign bus.dat_wr_index       = ctx_index_q[bus.mem_rsp_id];
  assign bus.dat_wr_way         = ctx_way_q[bus.mem_rsp_id];
  assign bus.dat_wr_beat        = beat_cnt_q;
  assign bus.dat_wr_data        = bus.mem_rsp_data;
  assign bus.v_linefill_done_en = done_q;
`ifdef L1D_LINEFILL_BEAT_CHK_EN
  assign err_beat               = err_q;
`endif
endmodule

// File: tb/tb_l1d_linefill_ctrl.sv
// Randomized bench for l1d_linefill_ctrl: requesters and a reordering memory are driven
// with $urandom and every output is compared against a transaction-level reference model.
module tb_l1d_linefill_ctrl;
  localparam int EN       = 8;
  localparam int TAG_W    = 20;
  localparam int INDEX_W  = 6;
  localparam int WAY_NUM  = 4;
  localparam int OFFSET_W = 6;
  localparam int BEAT_NUM = 4;
  localparam int DATA_W   = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  l1d_linefill_ctrl_if #(.ENTRY_NUM(EN), .ID_W(3), .TAG_W(TAG_W), .INDEX_W(INDEX_W),
                         .WAY_NUM(WAY_NUM), .OFFSET_W(OFFSET_W), .BEAT_NUM(BEAT_NUM),
                         .DATA_W(DATA_W)) bus ();
`ifdef L1D_LINEFILL_BEAT_CHK_EN
  logic err_beat;
`endif

  l1d_linefill_ctrl #(.ENTRY_NUM(EN), .ID_W(3), .TAG_W(TAG_W), .INDEX_W(INDEX_W),
                      .WAY_NUM(WAY_NUM), .OFFSET_W(OFFSET_W), .BEAT_NUM(BEAT_NUM),
                      .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef L1D_LINEFILL_BEAT_CHK_EN
    ,
    .err_beat (err_beat)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: fills in flight, pending done pulses, next RR start, issue slot, contexts
  bit                 m_infl [EN];
  bit                 m_done [EN];
  int                 m_ptr;
  bit                 m_slot_vld;
  logic [31:0]        m_slot_addr;
  int                 m_slot_id;
  logic [INDEX_W-1:0] m_ctx_idx [EN];
  logic [WAY_NUM-1:0] m_ctx_way [EN];
  bit                 m_err;

  // environment: requesters and memory
  bit                 ent_busy [EN];
  bit                 ent_req  [EN];
  logic [TAG_W-1:0]   p_tag [EN];
  logic [INDEX_W-1:0] p_idx [EN];
  logic [WAY_NUM-1:0] p_way [EN];
  int                 issued_q [$];
  bit                 burst_act;
  int                 burst_id;
  int                 burst_sent;

  int p_req, p_ghost, p_mrdy, p_rvld, p_drdy;
  bit only2, force_short;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    for (int off = 0; off < EN; off++) begin
      int e;
      e = (m_ptr + off) % EN;
      if (bus.v_req_vld[e] && !m_infl[e] && !m_done[e]) return e;
    end
    return -1;
  endfunction

  task automatic clear_state();
    for (int i = 0; i < EN; i++) begin
      m_infl[i] = 1'b0; m_done[i] = 1'b0; ent_busy[i] = 1'b0; ent_req[i] = 1'b0;
    end
    m_ptr = 0; m_slot_vld = 1'b0; m_slot_id = 0; m_slot_addr = '0; m_err = 1'b0;
    issued_q.delete();
    burst_act = 1'b0; burst_id = 0; burst_sent = 0;
  endtask

  task automatic drive_idle();
    bus.v_req_vld = '0; bus.mem_req_rdy = 1'b0; bus.mem_rsp_vld = 1'b0; bus.mem_rsp_id = '0;
    bus.mem_rsp_data = '0; bus.mem_rsp_last = 1'b0; bus.dat_wr_rdy = 1'b0;
    bus.v_req_tag = '0; bus.v_req_index = '0; bus.v_req_way = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    bus.v_req_vld = '1;
    #1;
    check_eq("rst_v_req_rdy", bus.v_req_rdy, '0);
    @(negedge clk);
    check_eq("rst_mem_req_vld", bus.mem_req_vld, 1'b0);
    check_eq("rst_done_en", bus.v_linefill_done_en, '0);
`ifdef L1D_LINEFILL_BEAT_CHK_EN
    check_eq("rst_err_beat", err_beat, 1'b0);
`endif
    bus.v_req_vld = '0;
    rst_n = 1'b1;
    clear_state();
  endtask

  task automatic cycle();
    int g, k;
    bit load, hs;
    logic [EN-1:0] expv, dvec;
    @(negedge clk);
    for (int i = 0; i < EN; i++) dvec[i] = m_done[i];
    check_eq("done_en", bus.v_linefill_done_en, dvec);
    for (int i = 0; i < EN; i++) if (bus.v_linefill_done_en[i]) ent_busy[i] = 1'b0;

    for (int i = 0; i < EN; i++) begin
      if (ent_busy[i]) begin
        bus.v_req_vld[i] = ($urandom_range(99) < p_ghost);
        p_tag[i] = TAG_W'($urandom); p_idx[i] = INDEX_W'($urandom);
        p_way[i] = WAY_NUM'(1) << $urandom_range(WAY_NUM-1);
      end else begin
        if (!ent_req[i] && ($urandom_range(99) < p_req) && (!only2 || i == 2)) begin
          ent_req[i] = 1'b1;
          if (only2) begin
            p_tag[i] = 20'h12345; p_idx[i] = 6'h05; p_way[i] = 4'b0100;
          end else begin
            p_tag[i] = TAG_W'($urandom); p_idx[i] = INDEX_W'($urandom);
            p_way[i] = WAY_NUM'(1) << $urandom_range(WAY_NUM-1);
          end
        end
        bus.v_req_vld[i] = ent_req[i];
      end
      bus.v_req_tag[i*TAG_W +: TAG_W]       = p_tag[i];
      bus.v_req_index[i*INDEX_W +: INDEX_W] = p_idx[i];
      bus.v_req_way[i*WAY_NUM +: WAY_NUM]   = p_way[i];
    end
    bus.mem_req_rdy = ($urandom_range(99) < p_mrdy);

    if (!burst_act && issued_q.size() > 0 && $urandom_range(1) == 1) begin
      k = $urandom_range(issued_q.size() - 1);
      burst_id = issued_q[k];
      issued_q.delete(k);
      burst_act = 1'b1;
      burst_sent = 0;
    end
    bus.mem_rsp_vld  = burst_act && ($urandom_range(99) < p_rvld);
    bus.mem_rsp_id   = 3'(burst_id);
    bus.mem_rsp_data = {$urandom, $urandom, $urandom, $urandom};
    bus.mem_rsp_last = force_short ? (burst_sent == 2) : (burst_sent == BEAT_NUM - 1);
    bus.dat_wr_rdy   = ($urandom_range(99) < p_drdy);
    #1;

    g = exp_grant();
    load = !m_slot_vld || bus.mem_req_rdy;
    expv = '0;
    if (g >= 0 && load) expv[g] = 1'b1;
    check_eq("v_req_rdy", bus.v_req_rdy, expv);
    check_eq("mem_req_vld", bus.mem_req_vld, m_slot_vld);
    if (m_slot_vld) begin
      check_eq("mem_req_addr", bus.mem_req_addr, m_slot_addr);
      check_eq("mem_req_id", bus.mem_req_id, m_slot_id);
    end
    check_eq("mem_rsp_rdy", bus.mem_rsp_rdy, bus.dat_wr_rdy);
    check_eq("dat_wr_vld", bus.dat_wr_vld, bus.mem_rsp_vld);
    if (bus.mem_rsp_vld) begin
      check_eq("dat_wr_index", bus.dat_wr_index, m_ctx_idx[burst_id]);
      check_eq("dat_wr_way", bus.dat_wr_way, m_ctx_way[burst_id]);
      check_eq("dat_wr_beat", bus.dat_wr_beat, burst_sent);
      check_eq("dat_wr_data", bus.dat_wr_data, bus.mem_rsp_data);
    end
`ifdef L1D_LINEFILL_BEAT_CHK_EN
    check_eq("err_beat", err_beat, m_err);
`endif

    // advance model across the coming clock edge
    hs = bus.mem_rsp_vld && bus.dat_wr_rdy;
    if (bus.mem_rsp_vld && ((bus.mem_rsp_last && burst_sent != BEAT_NUM - 1) ||
        (!bus.mem_rsp_last && burst_sent == BEAT_NUM - 1) || !m_infl[burst_id]))
      m_err = 1'b1;
    for (int i = 0; i < EN; i++) m_done[i] = 1'b0;
    if (hs && bus.mem_rsp_last) begin
      m_done[burst_id] = 1'b1;
      m_infl[burst_id] = 1'b0;
    end
    if (bus.mem_req_vld && bus.mem_req_rdy) issued_q.push_back(int'(bus.mem_req_id));
    if (m_slot_vld && bus.mem_req_rdy) m_slot_vld = 1'b0;
    if (g >= 0 && load) begin
      m_slot_vld   = 1'b1;
      m_slot_addr  = {p_tag[g], p_idx[g], {OFFSET_W{1'b0}}};
      m_slot_id    = g;
      m_ctx_idx[g] = p_idx[g];
      m_ctx_way[g] = p_way[g];
      m_infl[g]    = 1'b1;
      m_ptr        = (g + 1) % EN;
    end
    for (int i = 0; i < EN; i++) begin
      if (bus.v_req_rdy[i] && ent_req[i]) begin
        ent_req[i]  = 1'b0;
        ent_busy[i] = 1'b1;
      end
    end
    if (hs) begin
      if (bus.mem_rsp_last) begin
        burst_act = 1'b0;
        burst_sent = 0;
      end else begin
        burst_sent++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  initial begin
    bit idle;
    rst_n = 1'b0;
    drive_idle();
    clear_state();
    only2 = 1'b0; force_short = 1'b0;
    do_reset();

    // single fill of entry 2 with fixed payload, no backpressure
    only2 = 1'b1; p_req = 100; p_ghost = 0; p_mrdy = 100; p_rvld = 100; p_drdy = 100;
    run(20);
    only2 = 1'b0;

    // broad random traffic with stalls on every port
    p_req = 30; p_ghost = 20; p_mrdy = 60; p_rvld = 70; p_drdy = 70;
    run(1500);
    p_req = 80; p_mrdy = 0;
    run(20);
    p_mrdy = 100; p_rvld = 90; p_drdy = 90;
    run(200);
    p_mrdy = 60; p_drdy = 40;
    run(300);

    // reset in the middle of traffic, then traffic again
    do_reset();
    p_req = 40; p_mrdy = 70; p_rvld = 80; p_drdy = 70;
    run(400);

    // lines that end early on beat 2
    force_short = 1'b1;
    run(200);
    force_short = 1'b0;

    // drain everything with a bounded budget
    p_req = 0; p_ghost = 0; p_mrdy = 100; p_rvld = 100; p_drdy = 100;
    idle = 1'b0;
    for (int c = 0; c < 3000 && !idle; c++) begin
      cycle();
      idle = !m_slot_vld && issued_q.size() == 0 && !burst_act;
      for (int i = 0; i < EN; i++) if (ent_busy[i] || ent_req[i] || m_done[i]) idle = 1'b0;
    end
    check_eq("drain_complete", idle, 1'b1);
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
